// File: rtl/dbus16_pkg.sv
// dbus16_pkg: shared types and constants for the dbus16 data-bus bridge.
//   dbus16_state_t      : bridge FSM states
//   dbus16_req_t        : queued request {we, addr, wdata}
//   DBUS16_TIMEOUT_DATA : read data returned by a timed-out I/O read
package dbus16_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAM_ACC,
      ST_RAM_RSP,
      ST_IO_WAIT,
      ST_RSP
   } dbus16_state_t;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } dbus16_req_t;

   localparam logic [15:0] DBUS16_TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/dbus16_fifo.sv
// dbus16_fifo: 2-entry in-order request queue.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   push, push_data   : enqueue (ignored when full unless popping this cycle)
//   pop               : dequeue head (ignored when empty)
//   head              : oldest entry, valid while !empty
//   full, empty       : occupancy flags
module dbus16_fifo
   import dbus16_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        push,
   input  dbus16_req_t push_data,
   input  logic        pop,
   output dbus16_req_t head,
   output logic        full,
   output logic        empty
);

   dbus16_req_t mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic        do_push;
   logic        do_pop;

   assign empty   = (count == 2'd0);
   assign full    = (count == 2'd2);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= !wr_ptr;
         if (do_pop)  rd_ptr <= !rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/dbus16.sv
// dbus16: bridge between the cpu16 data port and data RAM / 8-bit I/O bus.
// Ports:
//   clk, reset_n                         : clock, asynchronous active-low reset
//   dat_rw_addr, dat_wr_data             : CPU address / write data
//   dat_rd_req, dat_wr_req               : one-cycle request strobes
//   dat_rd_data, dat_rd_rdy, dat_wr_rdy  : completion pulses (data zero when idle)
//   ram_addr, ram_wdata, ram_re, ram_we  : RAM port (ram_rdata 1-cycle latency)
//   io_addr, io_wdata, io_rd, io_wr      : I/O strobes held until io_ack
//   io_rdata, io_ack                     : I/O response
//   busy, err_ovf, err_timeout           : status, sticky error flags
// Build option: define DBUS16_TIMEOUT_EN to abort I/O waits after
// TIMEOUT_CYCLES cycles; otherwise I/O waits are unbounded.
module dbus16
   import dbus16_pkg::*;
#(
   parameter int unsigned RAM_AW         = 12,
   parameter logic [7:0]  IO_PAGE        = 8'hFF,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [15:0]       dat_rw_addr,
   input  logic [15:0]       dat_wr_data,
   input  logic              dat_rd_req,
   input  logic              dat_wr_req,
   output logic [15:0]       dat_rd_data,
   output logic              dat_rd_rdy,
   output logic              dat_wr_rdy,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [15:0]       ram_wdata,
   output logic              ram_re,
   output logic              ram_we,
   input  logic [15:0]       ram_rdata,
   output logic [7:0]        io_addr,
   output logic [15:0]       io_wdata,
   output logic              io_rd,
   output logic              io_wr,
   input  logic [15:0]       io_rdata,
   input  logic              io_ack,
   output logic              busy,
   output logic              err_ovf,
   output logic              err_timeout
);

   localparam int unsigned CUR_AW = (RAM_AW > 8) ? RAM_AW : 8;

   // The timeout counter is 16 bits wide.
   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("dbus16: TIMEOUT_CYCLES must be in 1..65535");
   end

   dbus16_state_t state, state_nx;
   dbus16_req_t   in_req, head, sel;
   logic          in_valid, idle, fifo_full, fifo_empty;
   logic          pop, bypass, take, push, drop, slots_full, sel_is_io;
   logic          timeout_hit;
   logic          cur_we;
   logic [CUR_AW-1:0] cur_addr;
   logic [15:0]   cur_wdata;
   logic [15:0]   io_data;

   // A simultaneous read+write keeps only the write.
   assign in_valid = dat_rd_req | dat_wr_req;
   assign in_req   = '{we: dat_wr_req, addr: dat_rw_addr, wdata: dat_wr_data};

   // An idle bridge with nothing queued starts the incoming request directly,
   // giving first-access latency of one cycle. The request being serviced
   // holds one of the two queue slots, so while busy only one more can wait.
   assign idle       = (state == ST_IDLE);
   assign pop        = idle && !fifo_empty;
   assign bypass     = idle && fifo_empty && in_valid;
   assign take       = pop || bypass;
   assign sel        = pop ? head : in_req;
   assign sel_is_io  = (sel.addr[15:8] == IO_PAGE);
   assign slots_full = fifo_full || (!fifo_empty && !idle);
   assign push       = in_valid && !bypass && (!slots_full || pop);
   assign drop       = in_valid && !bypass && !push;
   assign busy       = !fifo_empty || !idle;

   dbus16_fifo u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (in_req),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef DBUS16_TIMEOUT_EN
   logic [15:0] to_cnt;
   logic        err_timeout_q;

   assign timeout_hit = (state == ST_IO_WAIT) && !io_ack &&
                        (to_cnt == 16'(TIMEOUT_CYCLES - 1));
   assign err_timeout = err_timeout_q;

   // Held at zero outside IO_WAIT, so every wait starts from zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt        <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         to_cnt <= (state == ST_IO_WAIT) ? to_cnt + 16'd1 : '0;
         if (timeout_hit) err_timeout_q <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cur_we    <= 1'b0;
         cur_addr  <= '0;
         cur_wdata <= '0;
         io_data   <= '0;
         err_ovf   <= 1'b0;
      end else begin
         state <= state_nx;
         if (take) begin
            cur_we    <= sel.we;
            cur_addr  <= sel.addr[CUR_AW-1:0];
            cur_wdata <= sel.wdata;
         end
         if (state == ST_IO_WAIT && io_ack) io_data <= io_rdata;
         else if (timeout_hit)              io_data <= DBUS16_TIMEOUT_DATA;
         if (drop) err_ovf <= 1'b1;
      end
   end

   always_comb begin
      state_nx    = state;
      ram_addr    = '0;
      ram_wdata   = '0;
      ram_re      = 1'b0;
      ram_we      = 1'b0;
      io_addr     = '0;
      io_wdata    = '0;
      io_rd       = 1'b0;
      io_wr       = 1'b0;
      dat_rd_data = '0;
      dat_rd_rdy  = 1'b0;
      dat_wr_rdy  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (take) state_nx = sel_is_io ? ST_IO_WAIT : ST_RAM_ACC;
         end
         ST_RAM_ACC: begin
            ram_addr  = cur_addr[RAM_AW-1:0];
            ram_wdata = cur_wdata;
            if (cur_we) begin
               ram_we     = 1'b1;
               dat_wr_rdy = 1'b1;
               state_nx   = ST_IDLE;
            end else begin
               ram_re   = 1'b1;
               state_nx = ST_RAM_RSP;
            end
         end
         ST_RAM_RSP: begin
            dat_rd_data = ram_rdata;
            dat_rd_rdy  = 1'b1;
            state_nx    = ST_IDLE;
         end
         ST_IO_WAIT: begin
            io_addr  = cur_addr[7:0];
            io_wdata = cur_wdata;
            io_rd    = !cur_we;
            io_wr    = cur_we;
            if (io_ack || timeout_hit) state_nx = ST_RSP;
         end
         ST_RSP: begin
            if (cur_we) begin
               dat_wr_rdy = 1'b1;
            end else begin
               dat_rd_rdy  = 1'b1;
               dat_rd_data = io_data;
            end
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dbus16.sv
// tb_dbus16: directed self-checking bench for dbus16.
module tb_dbus16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] dat_rw_addr, dat_wr_data;
   logic        dat_rd_req, dat_wr_req;
   logic [15:0] dat_rd_data;
   logic        dat_rd_rdy, dat_wr_rdy;
   logic [11:0] ram_addr;
   logic [15:0] ram_wdata;
   logic        ram_re, ram_we;
   logic [15:0] ram_rdata;
   logic [7:0]  io_addr;
   logic [15:0] io_wdata;
   logic        io_rd, io_wr;
   logic [15:0] io_rdata;
   logic        io_ack;
   logic        busy, err_ovf, err_timeout;

   int tests  = 0;
   int failed = 0;
   int rd_pulses = 0;
   int wr_pulses = 0;

   always #5 clk = ~clk;

   dbus16 #(.RAM_AW(12), .IO_PAGE(8'hFF), .TIMEOUT_CYCLES(255)) dut (
      .clk(clk), .reset_n(reset_n),
      .dat_rw_addr(dat_rw_addr), .dat_wr_data(dat_wr_data),
      .dat_rd_req(dat_rd_req), .dat_wr_req(dat_wr_req),
      .dat_rd_data(dat_rd_data), .dat_rd_rdy(dat_rd_rdy), .dat_wr_rdy(dat_wr_rdy),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we),
      .ram_rdata(ram_rdata),
      .io_addr(io_addr), .io_wdata(io_wdata), .io_rd(io_rd), .io_wr(io_wr),
      .io_rdata(io_rdata), .io_ack(io_ack),
      .busy(busy), .err_ovf(err_ovf), .err_timeout(err_timeout)
   );

   // Synchronous RAM, one cycle read latency.
   logic [15:0] tmem [4096];
   always @(posedge clk) begin
      if (ram_we) tmem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= tmem[ram_addr];
   end

   always @(negedge clk) begin
      if (dat_rd_rdy === 1'b1) rd_pulses++;
      if (dat_wr_rdy === 1'b1) wr_pulses++;
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_bus();
      dat_rd_req = 1'b0; dat_wr_req = 1'b0;
      dat_rw_addr = '0;  dat_wr_data = '0;
      io_ack = 1'b0;     io_rdata = '0;
   endtask

   task automatic do_reset();
      idle_bus();
      reset_n = 1'b0;
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if ({ram_re, ram_we, io_rd, io_wr} !== 4'b0) begin
         failed++; $display("FAIL reset_strobes got %b want 0000", {ram_re, ram_we, io_rd, io_wr});
      end
      tests++;
      if ({dat_rd_rdy, dat_wr_rdy, dat_rd_data} !== 18'h0) begin
         failed++; $display("FAIL reset_rdy got %b%b data %h want 0", dat_rd_rdy, dat_wr_rdy, dat_rd_data);
      end
      tests++;
      if ({busy, err_ovf, err_timeout} !== 3'b0) begin
         failed++; $display("FAIL reset_status got %b want 000", {busy, err_ovf, err_timeout});
      end
      tests++;
      if ({ram_addr, io_addr, ram_wdata, io_wdata} !== 52'h0) begin
         failed++; $display("FAIL reset_buses got %h %h %h %h want 0", ram_addr, io_addr, ram_wdata, io_wdata);
      end
   endtask

   task automatic test_ram_write_read();
      @(negedge clk);
      dat_rw_addr = 16'h0010; dat_wr_data = 16'h1234; dat_wr_req = 1'b1;
      @(negedge clk);
      tests++;
      if (ram_we !== 1'b1 || ram_addr !== 12'h010 || ram_wdata !== 16'h1234 || dat_wr_rdy !== 1'b1) begin
         failed++; $display("FAIL ram_write we=%b addr=%h data=%h rdy=%b want 1 010 1234 1", ram_we, ram_addr, ram_wdata, dat_wr_rdy);
      end
      dat_wr_req = 1'b0;
      @(negedge clk);
      dat_rd_req = 1'b1;
      @(negedge clk);
      tests++;
      if (ram_re !== 1'b1 || ram_addr !== 12'h010 || dat_rd_rdy !== 1'b0) begin
         failed++; $display("FAIL ram_read_acc re=%b addr=%h rdy=%b want 1 010 0", ram_re, ram_addr, dat_rd_rdy);
      end
      dat_rd_req = 1'b0;
      @(negedge clk);
      tests++;
      if (dat_rd_rdy !== 1'b1 || dat_rd_data !== 16'h1234) begin
         failed++; $display("FAIL ram_read_rsp rdy=%b data=%h want 1 1234", dat_rd_rdy, dat_rd_data);
      end
      @(negedge clk);
      tests++;
      if (dat_rd_rdy !== 1'b0 || dat_rd_data !== 16'h0000 || busy !== 1'b0) begin
         failed++; $display("FAIL ram_read_after rdy=%b data=%h busy=%b want 0 0000 0", dat_rd_rdy, dat_rd_data, busy);
      end
   endtask

   task automatic test_io_read();
      int hi;
      hi = 0;
      @(negedge clk);
      dat_rw_addr = 16'hFF05; dat_rd_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         dat_rd_req = 1'b0;
         if (io_rd === 1'b1 && io_addr === 8'h05 && dat_rd_rdy === 1'b0 && ram_re === 1'b0) hi++;
         if (i == 5) begin io_ack = 1'b1; io_rdata = 16'hBEEF; end
      end
      @(negedge clk);
      tests++;
      if (hi != 6) begin
         failed++; $display("FAIL io_read_strobe_cycles got %0d want 6", hi);
      end
      tests++;
      if (io_rd !== 1'b0 || dat_rd_rdy !== 1'b1 || dat_rd_data !== 16'hBEEF) begin
         failed++; $display("FAIL io_read_rsp io_rd=%b rdy=%b data=%h want 0 1 BEEF", io_rd, dat_rd_rdy, dat_rd_data);
      end
      io_ack = 1'b0; io_rdata = '0;
      // Stray acks while idle must not start or complete anything.
      @(negedge clk);
      io_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || dat_rd_rdy !== 1'b0 || dat_wr_rdy !== 1'b0 || io_rd !== 1'b0) begin
         failed++; $display("FAIL io_stray_ack busy=%b rd=%b wr=%b io_rd=%b want 0 0 0 0", busy, dat_rd_rdy, dat_wr_rdy, io_rd);
      end
      io_ack = 1'b0;
   endtask

   task automatic test_io_write_min_latency();
      @(negedge clk);
      dat_rw_addr = 16'hFF07; dat_wr_data = 16'h5A5A; dat_wr_req = 1'b1;
      @(negedge clk);
      dat_wr_req = 1'b0;
      tests++;
      if (io_wr !== 1'b1 || io_rd !== 1'b0 || io_addr !== 8'h07 || io_wdata !== 16'h5A5A || dat_wr_rdy !== 1'b0) begin
         failed++; $display("FAIL io_write_strobe wr=%b rd=%b addr=%h data=%h rdy=%b want 1 0 07 5A5A 0", io_wr, io_rd, io_addr, io_wdata, dat_wr_rdy);
      end
      io_ack = 1'b1;
      @(negedge clk);
      io_ack = 1'b0;
      tests++;
      if (dat_wr_rdy !== 1'b1 || io_wr !== 1'b0 || dat_rd_rdy !== 1'b0) begin
         failed++; $display("FAIL io_write_rsp wr_rdy=%b io_wr=%b rd_rdy=%b want 1 0 0", dat_wr_rdy, io_wr, dat_rd_rdy);
      end
   endtask

   task automatic test_rd_wr_collision();
      int r0, w0;
      @(negedge clk);
      r0 = rd_pulses; w0 = wr_pulses;
      dat_rw_addr = 16'h0020; dat_wr_data = 16'h00AA; dat_rd_req = 1'b1; dat_wr_req = 1'b1;
      @(negedge clk);
      dat_rd_req = 1'b0; dat_wr_req = 1'b0;
      tests++;
      if (ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== 12'h020 || ram_wdata !== 16'h00AA || dat_wr_rdy !== 1'b1) begin
         failed++; $display("FAIL collision_access we=%b re=%b addr=%h data=%h rdy=%b want 1 0 020 00AA 1", ram_we, ram_re, ram_addr, ram_wdata, dat_wr_rdy);
      end
      repeat (4) @(negedge clk);
      tests++;
      if (rd_pulses - r0 != 0 || wr_pulses - w0 != 1) begin
         failed++; $display("FAIL collision_pulses rd=%0d wr=%0d want 0 1", rd_pulses - r0, wr_pulses - w0);
      end
      tests++;
      if (tmem[12'h020] !== 16'h00AA) begin
         failed++; $display("FAIL collision_mem got %h want 00AA", tmem[12'h020]);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] got [$];
      tests++;
      if (err_ovf !== 1'b0) begin
         failed++; $display("FAIL b2b_ovf_before got %b want 0", err_ovf);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (dat_rd_rdy === 1'b1) got.push_back(dat_rd_data);
         dat_rd_req  = (i < 3);
         dat_rw_addr = (i == 0) ? 16'h0010 : (i == 1) ? 16'h0020 : 16'h0030;
      end
      tests++;
      if (got.size() != 2) begin
         failed++; $display("FAIL b2b_count got %0d want 2", got.size());
      end
      tests++;
      if (got.size() < 1 || got[0] !== 16'h1234) begin
         failed++; $display("FAIL b2b_first got %h want 1234", (got.size() < 1) ? 16'hxxxx : got[0]);
      end
      tests++;
      if (got.size() < 2 || got[1] !== 16'h00AA) begin
         failed++; $display("FAIL b2b_second got %h want 00AA", (got.size() < 2) ? 16'hxxxx : got[1]);
      end
      tests++;
      if (err_ovf !== 1'b1 || busy !== 1'b0) begin
         failed++; $display("FAIL b2b_status err_ovf=%b busy=%b want 1 0", err_ovf, busy);
      end
   endtask

   task automatic test_timeout();
      int          hi;
      bit          done;
      logic [15:0] d;
      logic        rd_at_done;
      hi = 0; done = 1'b0; d = '0; rd_at_done = 1'b0;
      @(negedge clk);
      dat_rw_addr = 16'hFF10; dat_rd_req = 1'b1;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(negedge clk);
         dat_rd_req = 1'b0;
         if (dat_rd_rdy === 1'b1) begin
            done = 1'b1; d = dat_rd_data; rd_at_done = io_rd;
         end else if (io_rd === 1'b1) begin
            hi++;
         end
      end
`ifdef DBUS16_TIMEOUT_EN
      tests++;
      if (!done || hi != 255) begin
         failed++; $display("FAIL timeout_completion done=%0d strobe_cycles=%0d want 1 255", done, hi);
      end
      tests++;
      if (d !== 16'hDEAD || rd_at_done !== 1'b0) begin
         failed++; $display("FAIL timeout_data data=%h io_rd=%b want DEAD 0", d, rd_at_done);
      end
      tests++;
      if (err_timeout !== 1'b1) begin
         failed++; $display("FAIL timeout_flag got %b want 1", err_timeout);
      end
`else
      tests++;
      if (done || hi != 1000) begin
         failed++; $display("FAIL no_timeout_wait done=%0d strobe_cycles=%0d want 0 1000", done, hi);
      end
      tests++;
      if (io_rd !== 1'b1 || busy !== 1'b1 || err_timeout !== 1'b0) begin
         failed++; $display("FAIL no_timeout_state io_rd=%b busy=%b err=%b want 1 1 0", io_rd, busy, err_timeout);
      end
`endif
      do_reset();
   endtask

   task automatic test_reset_mid_op();
      int r0, w0;
      @(negedge clk);
      dat_rw_addr = 16'hFF20; dat_rd_req = 1'b1;
      @(negedge clk);
      dat_rd_req = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (io_rd !== 1'b1 || busy !== 1'b1) begin
         failed++; $display("FAIL midreset_pre io_rd=%b busy=%b want 1 1", io_rd, busy);
      end
      r0 = rd_pulses; w0 = wr_pulses;
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if (io_rd !== 1'b0 || busy !== 1'b0) begin
         failed++; $display("FAIL midreset_async io_rd=%b busy=%b want 0 0", io_rd, busy);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (rd_pulses != r0 || wr_pulses != w0 || err_ovf !== 1'b0) begin
         failed++; $display("FAIL midreset_quiet rd=%0d wr=%0d ovf=%b want %0d %0d 0", rd_pulses, wr_pulses, err_ovf, r0, w0);
      end
      dat_rw_addr = 16'h0010; dat_rd_req = 1'b1;
      @(negedge clk);
      dat_rd_req = 1'b0;
      tests++;
      if (ram_re !== 1'b1 || ram_addr !== 12'h010) begin
         failed++; $display("FAIL midreset_next_acc re=%b addr=%h want 1 010", ram_re, ram_addr);
      end
      @(negedge clk);
      tests++;
      if (dat_rd_rdy !== 1'b1 || dat_rd_data !== 16'h1234) begin
         failed++; $display("FAIL midreset_next_rsp rdy=%b data=%h want 1 1234", dat_rd_rdy, dat_rd_data);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      idle_bus();
      test_reset();
      test_ram_write_read();
      test_io_read();
      test_io_write_min_latency();
      test_rd_wr_collision();
      test_back_to_back();
      test_timeout();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
